cost_port_arbiter: RTL
======================

// Module: cost_port_arbiter
// PURPOSE
//  Shares the single Cost lookup port (W/J address out, 7-bit Cost back) between NREQ
//  permutation-search engines, so several engines can evaluate assignments in parallel.
//  Grants are bursts: the owning engine keeps the port for a whole permutation (up to
//  MAX_BURST lookups), so its running sum is never interleaved with another engine's.
//  Arbitration is round-robin. Each returned Cost is routed to the engine that issued it.
// PARAMETERS
//  NREQ       2   number of requesting search engines (2..4)
//  AW         3   width of W and J addresses
//  CW         7   width of Cost
//  MAX_BURST  8   max lookups per grant; a burst ends here even without req_last
//  STALL_MAX  15  idle owner cycles before its lock is revoked
// PORTS
//  CLK        in   1        clock, all state changes on rising edge
//  RST_N      in   1        asynchronous reset, active low
//  req        in   NREQ     per-engine lookup request (level, held until gnt)
//  req_w      in   NREQ*AW  per-engine worker index, engine i at [i*AW +: AW]
//  req_j      in   NREQ*AW  per-engine job index, same packing
//  req_last   in   NREQ     marks the final lookup of the engine's burst
//  gnt        out  NREQ     combinational one-hot accept strobe for this cycle's beat
//  W          out  AW       registered worker address to Cost table
//  J          out  AW       registered job address to Cost table
//  Cost       in   CW       table data, valid the cycle after W/J change
//  rdata      out  CW       registered Cost value returned to engines
//  rvalid     out  NREQ     one-hot, 1-cycle pulse, marks rdata for engine i
//  owner      out  2        index of current lock holder (valid when busy)
//  busy       out  1        a lock is held
//  abort      out  1        1-cycle pulse, lock revoked by stall timeout or MAX_BURST
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, W=J=0, rdata=0, rvalid=0, gnt=0, owner=0,
//   busy=0, abort=0, rr pointer set so engine 0 wins first. In-flight returns are dropped.
//  States: IDLE -> LOCK -> IDLE.
//   IDLE: if any req, pick first requesting i at or after rr pointer (wrapping); owner<=i,
//    busy<=1, beat count<=0, stall count<=0 -> LOCK. No gnt in IDLE.
//   LOCK: gnt[owner] = req[owner]; other gnt bits 0. On a beat (gnt high) W<=req_w,
//    J<=req_j of owner, count+1, stall count cleared.
//    Beat with req_last=1 -> IDLE, busy<=0, rr pointer<=owner+1 (mod NREQ).
//    Beat making count==MAX_BURST without req_last -> IDLE, abort pulse, pointer advances.
//    No beat for STALL_MAX consecutive cycles -> IDLE, abort pulse, pointer advances.
//  Returns: beat accepted at edge E drives W/J after E; Cost sampled at E+1; rdata and
//   rvalid[owner_of_beat] visible after E+1 (2-edge latency), one return per cycle,
//   fully pipelined. Owner tag travels with the beat, so returns complete after lock release.
//  Minimum gap between bursts: one IDLE cycle (no gnt). Back-to-back beats allowed.
//  Simultaneous req from all engines: strict round-robin, no engine waits >NREQ-1 bursts.
//  req from non-owner during LOCK: ignored, held by engine, no gnt.
//  W/J hold their last value when no beat occurs.
//  Reset asserted mid-burst: all outputs to reset values immediately; no stray rvalid.
// TESTING
//  1 Single engine: req0 burst W=0..7,J=7..0, last on 8th -> gnt0 8 cycles, 8 rvalid0
//    pulses with rdata=Cost(w,7-w), first 2 edges after first gnt; busy drops.
//  2 Both request at once from reset -> engine 0 bursts first, 1 IDLE cycle, then
//    engine 1; rvalid never sets bit 1 during engine 0 returns.
//  3 Engine 1 idles 15 cycles mid-burst -> abort pulse, busy=0, pending engine 0 granted.
//  4 Engine 0 issues 8 beats, never asserts last -> abort after 8th beat, lock released.
//  5 Owner drops req for 3 cycles mid-burst -> no gnt, W/J held, lock kept, resumes.
//  6 RST_N low one cycle after a beat -> rvalid stays 0, owner=0, W=J=0.

Source files
------------

// File: rtl/cost_port_arbiter.sv
// Round-robin burst arbiter sharing one Cost lookup port between NREQ search engines.
// Each beat carries its owner tag down the return pipe, so returns complete after release.
module cost_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 3,
  parameter int CW        = 7,
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 15
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_w,
  input  logic [NREQ*AW-1:0] req_j,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      W,
  output logic [AW-1:0]      J,
  input  logic [CW-1:0]      Cost,
  output logic [CW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic [1:0]         owner,
  output logic               busy,
  output logic               abort
);
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int SCW = $clog2(STALL_MAX + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d, rr_q, rr_d, tag_q, tag_d;
  logic [OW-1:0]  pick_idx, rr_next;
  logic [BCW-1:0] beat_q, beat_d, beat_inc;
  logic [SCW-1:0] stall_q, stall_d, stall_inc;
  logic [AW-1:0]  w_q, w_d, j_q, j_d, sel_w, sel_j;
  logic [CW-1:0]  rdata_q, rdata_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic           abort_q, abort_d, inflight_q, inflight_d;
  logic           pick_vld, sel_req, sel_last;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!pick_vld && req[i] && (i == (32'(rr_q) + k) % NREQ)) begin
          pick_vld = 1'b1;
          pick_idx = OW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_w    = '0;
    sel_j    = '0;
    gnt      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        sel_req  = req[i];
        sel_last = req_last[i];
        sel_w    = req_w[i*AW +: AW];
        sel_j    = req_j[i*AW +: AW];
        gnt[i]   = (state_q == LOCK) && req[i];
      end
    end
  end

  assign rr_next   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign beat_inc  = beat_q + 1'b1;
  assign stall_inc = stall_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    w_d        = w_q;
    j_d        = j_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    abort_d    = 1'b0;
    rdata_d    = inflight_q ? Cost : rdata_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid_d[i] = inflight_q && (tag_q == OW'(i));
    end
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCK;
          owner_d = pick_idx;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      LOCK: begin
        if (sel_req) begin
          w_d        = sel_w;
          j_d        = sel_j;
          tag_d      = owner_q;
          inflight_d = 1'b1;
          beat_d     = beat_inc;
          stall_d    = '0;
          if (sel_last || beat_inc == BCW'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = rr_next;
            abort_d = !sel_last;
          end
        end else begin
          stall_d = stall_inc;
          if (stall_inc == SCW'(STALL_MAX)) begin
            state_d = IDLE;
            rr_d    = rr_next;
            abort_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      tag_q      <= '0;
      beat_q     <= '0;
      stall_q    <= '0;
      w_q        <= '0;
      j_q        <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      abort_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      tag_q      <= tag_d;
      beat_q     <= beat_d;
      stall_q    <= stall_d;
      w_q        <= w_d;
      j_q        <= j_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      abort_q    <= abort_d;
      inflight_q <= inflight_d;
    end
  end

  assign W      = w_q;
  assign J      = j_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign owner  = 2'(owner_q);
  assign busy   = (state_q == LOCK);
  assign abort  = abort_q;

endmodule
